wlm_mul_serial: RTL
===================

# wlm_mul_serial

Digit-serial integer multiplier that computes the full-width product C = A·B and feeds it, together with the modulus high part qH, to the word-level Montgomery reduction stage (`wlm_mixed`). It sits directly upstream of the reduction in the modular-multiplication datapath. It trades throughput for area by consuming B one DW-bit digit per cycle. It uses valid/ready handshakes on both sides, so the reduction stage can be fed from a stream.

## Interface
- LOGQ, 60, operand width in bits; C is 2·LOGQ bits.
- LOGQH, 17, width of the qH sideband, passed through unchanged.
- DW, 16, digit width of B consumed per cycle; legal range 1 ≤ DW ≤ LOGQ.
- ND (localparam), ceil(LOGQ/DW), number of digits and BUSY cycles. It is 4 for the defaults.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  A, B and qH_in are valid.
- in_ready  out  1  block can accept an operand pair.
- A  in  LOGQ  multiplicand.
- B  in  LOGQ  multiplier, consumed digit-serially, LSB digit first.
- qH_in  in  LOGQH  modulus high part, captured with A and B.
- out_valid  out  1  C and qH_out are valid.
- out_ready  in  1  downstream accepts C.
- C  out  2·LOGQ  product A·B.
- qH_out  out  LOGQH  qH captured with the operands that produced C.

## Operation
- There are three states.
  - IDLE: in_ready = 1 and out_valid = 0.
  - BUSY: digits are accumulated.
  - DONE: out_valid = 1 and in_ready = 0.
- IDLE → BUSY on in_valid & in_ready. On that transition:
  - capture A and B, zero-extending B to ND·DW bits;
  - capture qH_in;
  - clear the accumulator (2·LOGQ+DW bits);
  - set the digit counter cnt = 0.
- BUSY, each cycle:
  - acc ← acc + (A · B[DW·cnt +: DW]) << (DW·cnt);
  - cnt ← cnt + 1;
  - after adding digit ND−1, go to DONE; cnt does not wrap.
- DONE:
  - C = acc[2·LOGQ−1:0]; the upper bits are provably zero;
  - qH_out = captured qH;
  - both outputs are held stable while out_ready = 0.
- DONE → IDLE on out_valid & out_ready.
- Only one operation is in flight at a time. in_valid is ignored outside IDLE.
- No modular reduction is done here; C < 2^(2·LOGQ) always holds.
- Reset, at any time including mid-BUSY or in DONE:
  - the current operation is aborted;
  - state returns to IDLE;
  - cnt, acc, C and qH_out are cleared to 0;
  - out_valid = 0;
  - in_ready = 0 while rst is high, and 1 from the first cycle after deassertion.

## Timing
- Accept at edge k. BUSY occupies edges k+1 … k+ND.
- out_valid rises after edge k+ND, i.e. latency is ND cycles from acceptance.
- If out_ready = 1 when out_valid rises, the result is consumed at edge k+ND+1, and in_ready is high in the following cycle.
- Peak throughput is one product per ND+2 cycles.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- The qH pairing with C is preserved exactly, with no skew.

## Test plan
- **Basic:** reset, then A=0x3, B=0x5 (LOGQ=60, DW=16) → out_valid exactly 4 cycles after accept, C=0xF, qH_out equal to the qH_in captured with it.
- **Maximum operands:** A=B=0xFFFFFFFFFFFFFFF, qH_in=0x1ABCD → C=0xFFFFFFFFFFFFFFE000000000000001, qH_out=0x1ABCD.
- **Top digit / shift:** A=0x123, B=0x800000000000000 (2^59) → C=0x91800000000000000. B=0 → C=0.
- **Backpressure:**
  - hold out_ready=0 for 10 cycles in DONE → C and qH_out stable, in_ready=0, a new in_valid pulse is not captured;
  - release out_ready → IDLE the next cycle.
- **Reset mid-BUSY:** assert rst after 2 BUSY cycles → out_valid=0 and C=0 immediately; after deassertion in_ready=1, and a fresh A=7, B=9 yields C=0x3F.
- **Stream:** 1000 random (A, B, qH) pairs with in_valid held high and random out_ready, compared against a reference model → all products and qH pairings correct and in order, none dropped or duplicated.

Source files
------------

// File: rtl/wlm_mul_serial.sv
// Digit-serial multiplier: C = A*B, consuming B one DW-bit digit per cycle, LSB digit first.
// The qH sideband rides along with its operands so it stays paired with the product it belongs to.
module wlm_mul_serial #(
   parameter int LOGQ  = 60,
   parameter int LOGQH = 17,
   parameter int DW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LOGQ-1:0]     A,
   input  logic [LOGQ-1:0]     B,
   input  logic [LOGQH-1:0]    qH_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*LOGQ-1:0]   C,
   output logic [LOGQH-1:0]    qH_out
);

   localparam int ND   = (LOGQ + DW - 1) / DW;
   localparam int BW   = ND * DW;
   localparam int PPW  = LOGQ + DW;
   localparam int CBW  = 2 * LOGQ;
   localparam int CW   = (ND > 1) ? $clog2(ND) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              load;
   logic              step;

   logic [LOGQ-1:0]   a_reg;
   logic [BW-1:0]     b_reg;
   logic [LOGQH-1:0]  qh_reg;
   logic [CBW-1:0]    acc_reg;
   logic [CBW-1:0]    acc_next;
   logic [CW-1:0]     cnt_reg;

   logic [DW-1:0]     b_dig [ND];
   logic [PPW-1:0]    pp;
   logic [CBW-1:0]    pp_shifted;

   // Split the zero-extended B into its digits so cnt can select one.
   for (genvar gi = 0; gi < ND; gi++) begin : g_digit
      assign b_dig[gi] = b_reg[gi*DW +: DW];
   end

   // Every partial sum is bounded by the final product (< 2^(2*LOGQ)), so the
   // bits above 2*LOGQ of the nominal accumulator are always zero and are not stored.
   assign pp         = PPW'(a_reg) * PPW'(b_dig[cnt_reg]);
   assign pp_shifted = CBW'(pp) << (DW * cnt_reg);
   assign acc_next   = acc_reg + pp_shifted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      case (state_reg)
         IDLE: begin
            // Held low while reset is asserted, high from the first cycle after release.
            in_ready = ~rst;
            if (in_valid && !rst) begin
               load       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (cnt_reg == CNT_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         qh_reg  <= '0;
         acc_reg <= '0;
         cnt_reg <= '0;
      end else if (load) begin
         a_reg   <= A;
         b_reg   <= BW'(B);
         qh_reg  <= qH_in;
         acc_reg <= '0;
         cnt_reg <= '0;
      end else if (step) begin
         acc_reg <= acc_next;
         if (cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign C      = acc_reg;
   assign qH_out = qh_reg;

endmodule
